// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data width, parity, stop bits and oversampling.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit point.
module uart_rx_cfg #(
  parameter int unsigned CLOCK_RATE = 12000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxEn,
  input  logic                 rxIn,
  output logic                 rxBusy,
  output logic                 rxDone,
  output logic                 rxErr,
  output logic                 rxParityErr,
  output logic                 rxFrameErr,
  output logic [DATA_BITS-1:0] rxOut
);

  localparam int unsigned TICK_RATE = BAUD_RATE * OVERSAMPLE;
  localparam int unsigned DIV_RAW   = (CLOCK_RATE + TICK_RATE / 2) / TICK_RATE;
  localparam int unsigned DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DW        = $clog2(DIV + 1);
  localparam int unsigned OW        = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [OW-1:0] PT_A      = OW'(OVERSAMPLE / 2 - 2);
  localparam logic [OW-1:0] PT_B      = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] PT_DECIDE = OW'(OVERSAMPLE / 2);
`else
  localparam logic [OW-1:0] PT_DECIDE = OW'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_DONE, ST_WAIT_IDLE
  } state_t;

  state_t               state;
  logic                 sync1, line, line_d;
  logic [DW-1:0]        div_cnt;
  logic [OW-1:0]        os_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_fail, frm_fail;
  logic                 tick, decide, bit_val;
`ifdef UART_RX_MAJORITY_EN
  logic                 s_a, s_b;
`endif

  // os_cnt holds the number of ticks already elapsed in the current bit,
  // so the k-th tick of a bit fires while os_cnt == k-1.
  always_comb begin
    tick   = (div_cnt == DIV_LAST);
    decide = tick && (os_cnt == PT_DECIDE);
`ifdef UART_RX_MAJORITY_EN
    bit_val = (s_a & s_b) | (s_a & line) | (s_b & line);
`else
    bit_val = line;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      sync1       <= 1'b1;
      line        <= 1'b1;
      line_d      <= 1'b1;
      div_cnt     <= '0;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_fail    <= 1'b0;
      frm_fail    <= 1'b0;
      rxBusy      <= 1'b0;
      rxDone      <= 1'b0;
      rxErr       <= 1'b0;
      rxParityErr <= 1'b0;
      rxFrameErr  <= 1'b0;
      rxOut       <= '0;
`ifdef UART_RX_MAJORITY_EN
      s_a         <= 1'b1;
      s_b         <= 1'b1;
`endif
    end else begin
      sync1  <= rxIn;
      line   <= sync1;
      line_d <= line;
      rxDone <= 1'b0;
      rxErr  <= 1'b0;

      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
`ifdef UART_RX_MAJORITY_EN
      if (tick && os_cnt == PT_A) s_a <= line;
      if (tick && os_cnt == PT_B) s_b <= line;
`endif

      if (!rxEn && state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
        state  <= ST_IDLE;
        rxBusy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rxEn && line_d && !line) begin
              state    <= ST_START;
              rxBusy   <= 1'b1;
              div_cnt  <= '0;
              os_cnt   <= '0;
              bit_cnt  <= '0;
              par_fail <= 1'b0;
              frm_fail <= 1'b0;
            end
          end
          ST_START: begin
            if (decide) begin
              if (bit_val) begin
                state  <= ST_IDLE;
                rxBusy <= 1'b0;
              end else begin
                state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (decide) begin
              shreg <= {bit_val, shreg[DATA_BITS-1:1]};
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_PARITY: begin
            if (decide) begin
              par_fail <= ((^shreg) ^ bit_val) != (PARITY == 1);
              state    <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (decide) begin
              if (bit_cnt == STOP_LAST) begin
                // Outputs are registered on entry so rxDone is high during DONE.
                state       <= ST_DONE;
                rxBusy      <= 1'b0;
                rxDone      <= 1'b1;
                rxOut       <= shreg;
                rxParityErr <= par_fail;
                rxFrameErr  <= frm_fail | ~bit_val;
                rxErr       <= par_fail | frm_fail | ~bit_val;
              end else begin
                frm_fail <= frm_fail | ~bit_val;
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end
          end
          ST_DONE: begin
            state <= line ? ST_IDLE : ST_WAIT_IDLE;
          end
          ST_WAIT_IDLE: begin
            if (line) state <= ST_IDLE;
          end
          default: begin
            state  <= ST_IDLE;
            rxBusy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: default 8N1 instance plus a fast even-parity instance.
module tb_uart_rx_cfg;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk;
  logic       rst0, en0, line0, busy0, done0, err0, pe0, fe0;
  logic       rst1, en1, line1, busy1, done1, err1, pe1, fe1;
  logic [7:0] out0, out1;
  int         checks, errors;
  exp_t       q0[$], q1[$];
  exp_t       e0, e1;

  uart_rx_cfg u_def (
    .clk(clk), .reset(rst0), .rxEn(en0), .rxIn(line0),
    .rxBusy(busy0), .rxDone(done0), .rxErr(err0),
    .rxParityErr(pe0), .rxFrameErr(fe0), .rxOut(out0)
  );

  // DIV = 8, so one bit is 128 clk.
  uart_rx_cfg #(
    .CLOCK_RATE(1228800), .BAUD_RATE(9600), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) u_cfg (
    .clk(clk), .reset(rst1), .rxEn(en1), .rxIn(line1),
    .rxBusy(busy1), .rxDone(done1), .rxErr(err1),
    .rxParityErr(pe1), .rxFrameErr(fe1), .rxOut(out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done0: got rxDone with rxOut=%0h, required no rxDone", out0);
      end else begin
        e0 = q0.pop_front();
        chk("data0", out0, e0.d);
        chk("perr0", pe0, e0.pe);
        chk("ferr0", fe0, e0.fe);
        chk("err0", err0, e0.pe | e0.fe);
        chk("busy_at_done0", busy0, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done1: got rxDone with rxOut=%0h, required no rxDone", out1);
      end else begin
        e1 = q1.pop_front();
        chk("data1", out1, e1.d);
        chk("perr1", pe1, e1.pe);
        chk("ferr1", fe1, e1.fe);
        chk("err1", err1, e1.pe | e1.fe);
        chk("busy_at_done1", busy1, 0);
      end
    end
  end

  task automatic set_line(input int ch, input logic v);
    if (ch == 0) line0 = v;
    else         line1 = v;
  endtask

  // Drives n bits LSB first; gbit selects a bit that gets a 1-clk low glitch at mid-bit.
  task automatic drive(input int ch, input logic [15:0] bits, input int n,
                       input int clks, input int gbit);
    for (int i = 0; i < n; i++) begin
      set_line(ch, bits[i]);
      if (i == gbit) begin
        repeat (clks / 2) @(negedge clk);
        set_line(ch, 1'b0);
        @(negedge clk);
        set_line(ch, bits[i]);
        repeat (clks - clks / 2 - 1) @(negedge clk);
      end else begin
        repeat (clks) @(negedge clk);
      end
    end
  endtask

  task automatic send0(input logic [7:0] d, input int clks);
    q0.push_back('{d: d, pe: 1'b0, fe: 1'b0});
    drive(0, {6'b0, 1'b1, d, 1'b0}, 10, clks, -1);
    repeat (clks) @(negedge clk);
  endtask

  task automatic send1(input logic [7:0] d, input logic p, input logic pe,
                       input int clks, input int gbit);
    q1.push_back('{d: d, pe: pe, fe: 1'b0});
    drive(1, {5'b0, 1'b1, p, d, 1'b0}, 11, clks, gbit);
    repeat (2 * clks) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst0 = 1'b1; rst1 = 1'b1;
    en0 = 1'b1;  en1 = 1'b1;
    line0 = 1'b1; line1 = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_busy0", busy0, 0);
    chk("reset_out0", out0, 0);
    chk("reset_flags0", {done0, err0, pe0, fe0}, 0);
    chk("reset_busy1", busy1, 0);
    chk("reset_out1", out1, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (20) @(negedge clk);

    // Default 8N1 frame, busy tracked across the frame.
    chk("busy_idle0", busy0, 0);
    fork
      send0(8'h35, 1248);
      begin
        repeat (600) @(negedge clk);
        chk("busy_mid0", busy0, 1);
      end
    join
    chk("busy_after0", busy0, 0);
    chk("hold_out0", out0, 8'h35);

    // 400-clk glitch: false start, no rxDone, no error.
    line0 = 1'b0;
    repeat (300) @(negedge clk);
    chk("busy_glitch0", busy0, 1);
    repeat (100) @(negedge clk);
    line0 = 1'b1;
    repeat (700) @(negedge clk);
    chk("busy_false_start0", busy0, 0);
    chk("err_false_start0", {pe0, fe0}, 0);

    // +/-3 % bit period on the default instance.
    send0(8'h00, 1286);
    send0(8'hFF, 1211);

    // Parity: 0x35 has even parity 0; sending 1 must flag an error.
    send1(8'h35, 1'b1, 1'b1, 128, -1);
    chk("sticky_perr1", pe1, 1);
    send1(8'hA5, 1'b0, 1'b0, 128, -1);
    chk("perr_cleared1", pe1, 0);

    // Stop bit held low for 3 bit times.
    q1.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b1});
    drive(1, {6'b0, 1'b0, 8'h5A, 1'b0}, 10, 128, -1);
    line1 = 1'b0;
    repeat (384) @(negedge clk);
    chk("busy_break1", busy1, 0);
    line1 = 1'b1;
    repeat (256) @(negedge clk);
    chk("sticky_ferr1", fe1, 1);
    send1(8'h3C, 1'b0, 1'b0, 128, -1);
    chk("ferr_cleared1", fe1, 0);

    // +/-3 % bit period on the parity instance.
    send1(8'h00, 1'b0, 1'b0, 132, -1);
    send1(8'hFF, 1'b0, 1'b0, 132, -1);
    send1(8'h35, 1'b0, 1'b0, 132, -1);
    send1(8'h00, 1'b0, 1'b0, 124, -1);
    send1(8'hFF, 1'b0, 1'b0, 124, -1);
    send1(8'h35, 1'b0, 1'b0, 124, -1);

`ifdef UART_RX_MAJORITY_EN
    send1(8'hFF, 1'b0, 1'b0, 128, 4);
`endif

    // Reset four bits into a frame.
    drive(1, 16'h0000, 4, 128, -1);
    rst1 = 1'b1;
    line1 = 1'b1;
    @(negedge clk);
    chk("midreset_busy1", busy1, 0);
    chk("midreset_out1", out1, 0);
    chk("midreset_flags1", {done1, err1, pe1, fe1}, 0);
    rst1 = 1'b0;
    repeat (256) @(negedge clk);
    send1(8'hC3, 1'b0, 1'b0, 128, -1);

    // rxEn dropped mid-frame: abort, no rxDone, rxOut kept.
    fork
      drive(1, {5'b0, 1'b1, 1'b0, 8'h96, 1'b0}, 11, 128, -1);
      begin
        repeat (128 * 4 + 10) @(negedge clk);
        chk("busy_before_abort1", busy1, 1);
        en1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_abort1", busy1, 0);
      end
    join
    repeat (256) @(negedge clk);
    chk("out_after_abort1", out1, 8'hC3);
    en1 = 1'b1;
    repeat (16) @(negedge clk);
    send1(8'h69, 1'b0, 1'b0, 128, -1);

    repeat (200) @(negedge clk);
    chk("pending0", q0.size(), 0);
    chk("pending1", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
